// File: rtl/dcache_seq_if.sv
// CPU, cache-control and memory-bus signals of the data-cache miss/flush sequencer.
// The master side is the sequencer; the slave side is the cache, CPU and bus arbiter.
interface dcache_seq_if #(
    parameter int LINE_LENGTH = 4,
    parameter int NLINES      = 4,
    parameter int PA          = 22
);
    localparam int LB = $clog2(LINE_LENGTH);
    localparam int TW = PA - LB;
    localparam int IW = (NLINES > 1) ? $clog2(NLINES) : 1;

    logic [1:0]    cpu_read;
    logic [1:0]    cpu_write;
    logic          cpu_fault;
    logic          cpu_ready;
    logic          flush_req;
    logic          flush_busy;
    logic          c_hit;
    logic          c_push;
    logic          c_pull;
    logic [TW-1:0] c_tag;
    logic          c_index_sel;
    logic [IW-1:0] c_index;
    logic          c_flush_write;
    logic          c_rstrobe;
    logic          c_wstrobe;
    logic          mem_req;
    logic          mem_we;
    logic [TW-1:0] mem_addr;
    logic          mem_gnt;

    modport master (
        input  cpu_read, cpu_write, cpu_fault, flush_req,
        input  c_hit, c_push, c_pull, c_tag, mem_gnt,
        output cpu_ready, flush_busy, c_index_sel, c_index, c_flush_write,
        output c_rstrobe, c_wstrobe, mem_req, mem_we, mem_addr
    );

    modport slave (
        output cpu_read, cpu_write, cpu_fault, flush_req,
        output c_hit, c_push, c_pull, c_tag, mem_gnt,
        input  cpu_ready, flush_busy, c_index_sel, c_index, c_flush_write,
        input  c_rstrobe, c_wstrobe, mem_req, mem_we, mem_addr
    );
endinterface

// File: rtl/dcache_seq.sv
// Data-cache miss/flush sequencer: stalls the CPU on a miss, wins the nibble bus and
// strobes contiguous line read-out (writeback) or fill beats; walks all lines on a flush.
module dcache_seq #(
    parameter int LINE_LENGTH = 4,
    parameter int NLINES      = 4,
    parameter int PA          = 22
) (
    input  logic         clk,
    input  logic         reset,
    dcache_seq_if.master bus
);
    localparam int LB  = $clog2(LINE_LENGTH);
    localparam int TW  = PA - LB;
    localparam int IW  = (NLINES > 1) ? $clog2(NLINES) : 1;
    localparam int NIB = 2 * LINE_LENGTH;
    localparam int BW  = $clog2(NIB);

    localparam logic [BW-1:0] BEAT_LAST = BW'(NIB - 1);
    localparam logic [IW-1:0] FIDX_LAST = IW'(NLINES - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WB_REQ   = 3'd1;
    localparam logic [2:0] WB       = 3'd2;
    localparam logic [2:0] FILL_REQ = 3'd3;
    localparam logic [2:0] FILL     = 3'd4;
    localparam logic [2:0] FSCAN    = 3'd5;

    logic [2:0]    state_reg, state_next;
    logic [BW-1:0] beat_reg, beat_next;
    logic [IW-1:0] fidx_reg, fidx_next;
    logic          flush_reg, flush_next;
    logic          mem_we_reg, mem_we_next;
    logic [TW-1:0] mem_addr_reg, mem_addr_next;
    logic          access;

    assign access = (|bus.cpu_read) || (|bus.cpu_write);

    always_comb begin
        state_next    = state_reg;
        beat_next     = beat_reg;
        fidx_next     = fidx_reg;
        flush_next    = flush_reg;
        mem_we_next   = mem_we_reg;
        mem_addr_next = mem_addr_reg;
        case (state_reg)
            IDLE: begin
                if (bus.flush_req) begin
                    state_next = FSCAN;
                    fidx_next  = '0;
                    flush_next = 1'b1;
                end else if (access && !bus.cpu_fault && !bus.c_hit) begin
                    // A dirty victim must leave before the fill; the re-evaluation
                    // after the writeback then sees a clean line and pulls.
                    if (bus.c_push) begin
                        mem_addr_next = bus.c_tag;
                        mem_we_next   = 1'b1;
                        state_next    = WB_REQ;
                    end else if (bus.c_pull) begin
                        mem_addr_next = bus.c_tag;
                        mem_we_next   = 1'b0;
                        state_next    = FILL_REQ;
                    end
                end
            end
            WB_REQ: begin
                if (bus.mem_gnt) begin
                    state_next = WB;
                    beat_next  = '0;
                end
            end
            FILL_REQ: begin
                if (bus.mem_gnt) begin
                    state_next = FILL;
                    beat_next  = '0;
                end
            end
            WB: begin
                if (beat_reg == BEAT_LAST) begin
                    beat_next  = '0;
                    state_next = flush_reg ? FSCAN : IDLE;
                end else begin
                    beat_next = beat_reg + 1'b1;
                end
            end
            FILL: begin
                if (beat_reg == BEAT_LAST) begin
                    beat_next  = '0;
                    state_next = IDLE;
                end else begin
                    beat_next = beat_reg + 1'b1;
                end
            end
            FSCAN: begin
                // fidx holds on a writeback so the same line is rescanned once clean.
                if (bus.c_push) begin
                    mem_addr_next = bus.c_tag;
                    mem_we_next   = 1'b1;
                    state_next    = WB_REQ;
                end else if (fidx_reg == FIDX_LAST) begin
                    fidx_next  = '0;
                    flush_next = 1'b0;
                    state_next = IDLE;
                end else begin
                    fidx_next = fidx_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            beat_reg     <= '0;
            fidx_reg     <= '0;
            flush_reg    <= 1'b0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            beat_reg     <= beat_next;
            fidx_reg     <= fidx_next;
            flush_reg    <= flush_next;
            mem_we_reg   <= mem_we_next;
            mem_addr_reg <= mem_addr_next;
        end
    end

    // Strobes decode straight from state so an async reset kills them at once.
    assign bus.cpu_ready     = (state_reg == IDLE) && !bus.flush_req && access &&
                               (bus.cpu_fault || bus.c_hit);
    assign bus.flush_busy    = flush_reg;
    assign bus.c_index_sel   = flush_reg;
    assign bus.c_flush_write = flush_reg;
    assign bus.c_index       = fidx_reg;
    assign bus.c_rstrobe     = (state_reg == WB);
    assign bus.c_wstrobe     = (state_reg == FILL);
    assign bus.mem_req       = (state_reg == WB_REQ) || (state_reg == WB) ||
                               (state_reg == FILL_REQ) || (state_reg == FILL);
    assign bus.mem_we        = mem_we_reg;
    assign bus.mem_addr      = mem_addr_reg;
endmodule

// File: tb/tb_dcache_seq.sv
// Bench for dcache_seq: a line-level cache model answers hit/push/pull, an arbiter model
// grants after a chosen delay, and each access or flush is checked against expectations.
module tb_dcache_seq;
    localparam int LINE_LENGTH = 4;
    localparam int NLINES      = 4;
    localparam int PA          = 22;
    localparam int LB          = $clog2(LINE_LENGTH);
    localparam int TW          = PA - LB;
    localparam int IW          = $clog2(NLINES);
    localparam int NIB         = 2 * LINE_LENGTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dcache_seq_if #(.LINE_LENGTH(LINE_LENGTH), .NLINES(NLINES), .PA(PA)) bus ();

    dcache_seq #(.LINE_LENGTH(LINE_LENGTH), .NLINES(NLINES), .PA(PA)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Cache contents as the bench believes them to be.
    bit            line_valid [NLINES];
    bit            line_dirty [NLINES];
    logic [TW-1:0] line_tag   [NLINES];
    logic [TW-1:0] cpu_line;
    logic [IW-1:0] ridx;

    int vectors = 0;
    int miscompares = 0;
    int req_cycles, r_cycles, w_cycles, busy_cycles, sig_bad;
    int rrun = 0, wrun = 0, req_wait = 0, gnt_delay = 0;
    logic [TW-1:0] wb_tag_q[$];
    logic [TW-1:0] fill_tag_q[$];
    int            wb_idx_q[$];
    bit            wb_we_q[$];
    bit            fill_we_q[$];

    always_comb begin
        ridx       = cpu_line[IW-1:0];
        bus.c_hit  = 1'b0;
        bus.c_push = 1'b0;
        bus.c_pull = 1'b0;
        bus.c_tag  = '0;
        if (bus.c_index_sel) begin
            bus.c_push = line_valid[bus.c_index] && line_dirty[bus.c_index];
            bus.c_tag  = line_tag[bus.c_index];
        end else begin
            bus.c_hit  = line_valid[ridx] && (line_tag[ridx] == cpu_line);
            bus.c_push = !bus.c_hit && line_valid[ridx] && line_dirty[ridx];
            bus.c_pull = !bus.c_hit && !bus.c_push;
            bus.c_tag  = bus.c_push ? line_tag[ridx] : cpu_line;
        end
    end

    task automatic clear_stats();
        req_cycles = 0; r_cycles = 0; w_cycles = 0; busy_cycles = 0; sig_bad = 0;
        wb_tag_q.delete(); fill_tag_q.delete(); wb_idx_q.delete();
        wb_we_q.delete(); fill_we_q.delete();
    endtask

    // Called at the falling edge: updates the cache model, records bus activity, drives grant.
    task automatic observe();
        int idx;
        if (bus.mem_req)   req_cycles++;
        if (bus.c_rstrobe) r_cycles++;
        if (bus.c_wstrobe) w_cycles++;
        if (bus.flush_busy) busy_cycles++;
        if (bus.c_index_sel !== bus.flush_busy || bus.c_flush_write !== bus.flush_busy) sig_bad++;
        if (bus.cpu_ready && (|bus.cpu_write) && !bus.cpu_fault) line_dirty[cpu_line[IW-1:0]] = 1'b1;
        if (bus.mem_req && !bus.c_rstrobe && !bus.c_wstrobe) begin
            bus.mem_gnt = (req_wait == gnt_delay);
            req_wait++;
        end else begin
            bus.mem_gnt = 1'b0;
            req_wait = 0;
        end
        // A line moves only after NIB unbroken strobes; any gap restarts the count.
        if (bus.c_rstrobe) begin
            rrun++;
            if (rrun == NIB) begin
                idx = bus.c_index_sel ? int'(bus.c_index) : int'(bus.mem_addr[IW-1:0]);
                wb_tag_q.push_back(bus.mem_addr);
                wb_idx_q.push_back(idx);
                wb_we_q.push_back(bus.mem_we);
                line_dirty[idx] = 1'b0;
                if (bus.c_flush_write) line_valid[idx] = 1'b0;
                rrun = 0;
            end
        end else rrun = 0;
        if (bus.c_wstrobe) begin
            wrun++;
            if (wrun == NIB) begin
                idx = int'(bus.mem_addr[IW-1:0]);
                fill_tag_q.push_back(bus.mem_addr);
                fill_we_q.push_back(bus.mem_we);
                line_valid[idx] = 1'b1;
                line_dirty[idx] = 1'b0;
                line_tag[idx]   = bus.mem_addr;
                wrun = 0;
            end
        end else wrun = 0;
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input logic [TW-1:0] line, input logic [1:0] rd, input logic [1:0] wr,
                             input bit flt, input int d);
        int idx, lat, exp_lat, exp_req;
        bit hit, exp_wb, exp_fill, done;
        logic [TW-1:0] victim;
        idx      = int'(line[IW-1:0]);
        hit      = line_valid[idx] && (line_tag[idx] == line);
        victim   = line_tag[idx];
        exp_wb   = !flt && !hit && line_valid[idx] && line_dirty[idx];
        exp_fill = !flt && !hit;
        exp_lat  = !exp_fill ? 1 : (exp_wb ? 2 * (1 + (d + 1) + NIB) + 1 : 1 + (d + 1) + NIB + 1);
        exp_req  = (int'(exp_wb) + int'(exp_fill)) * (d + 1 + NIB);
        clear_stats();
        gnt_delay     = d;
        cpu_line      = line;
        bus.cpu_read  = rd;
        bus.cpu_write = wr;
        bus.cpu_fault = flt;
        done = 1'b0;
        lat  = 0;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
            done = bus.cpu_ready;
            observe();
            @(posedge clk);
            #1;
        end
        bus.cpu_read  = 2'b00;
        bus.cpu_write = 2'b00;
        bus.cpu_fault = 1'b0;
        $display("access line=%h rd=%b wr=%b fault=%0d gnt_delay=%0d cycles=%0d expected=%0d",
                 line, rd, wr, flt, d, lat, exp_lat);
        vectors++;
        if (!done || lat != exp_lat) begin
            miscompares++;
            $display("FAIL latency line=%h: got %0d cycles (ready seen=%0d), required %0d",
                     line, lat, done, exp_lat);
        end
        vectors++;
        if (wb_tag_q.size() != int'(exp_wb)) begin
            miscompares++;
            $display("FAIL wb_count line=%h: got %0d writebacks, required %0d", line, wb_tag_q.size(), exp_wb);
        end else if (exp_wb) begin
            vectors++;
            if (wb_tag_q[0] !== victim || wb_we_q[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL wb_addr: got addr=%h we=%0d, required addr=%h we=1", wb_tag_q[0], wb_we_q[0], victim);
            end
        end
        vectors++;
        if (fill_tag_q.size() != int'(exp_fill)) begin
            miscompares++;
            $display("FAIL fill_count line=%h: got %0d fills, required %0d", line, fill_tag_q.size(), exp_fill);
        end else if (exp_fill) begin
            vectors++;
            if (fill_tag_q[0] !== line || fill_we_q[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL fill_addr: got addr=%h we=%0d, required addr=%h we=0", fill_tag_q[0], fill_we_q[0], line);
            end
        end
        vectors++;
        if (req_cycles != exp_req || r_cycles != int'(exp_wb) * NIB || w_cycles != int'(exp_fill) * NIB) begin
            miscompares++;
            $display("FAIL bus_cycles line=%h: got req=%0d rd=%0d wr=%0d, required req=%0d rd=%0d wr=%0d",
                     line, req_cycles, r_cycles, w_cycles, exp_req, int'(exp_wb) * NIB, int'(exp_fill) * NIB);
        end
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        outs = {bus.cpu_ready, bus.flush_busy, bus.c_index_sel, bus.c_flush_write, bus.c_rstrobe,
                bus.c_wstrobe, bus.mem_req, bus.mem_we, bus.c_index};
        vectors++;
        if (outs !== 10'b0 || bus.mem_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got flags=%b addr=%h, required all zero", outs, bus.mem_addr);
        end
        reset = 1'b0;
        clear_stats();
        repeat (3) step();
        vectors++;
        if (req_cycles != 0 || busy_cycles != 0) begin
            miscompares++;
            $display("FAIL reset_idle: got req=%0d busy=%0d cycles, required 0", req_cycles, busy_cycles);
        end
    endtask

    task automatic test_hit();
        line_valid[1] = 1'b1; line_dirty[1] = 1'b0; line_tag[1] = 20'h00005;
        do_access(20'h00005, 2'b01, 2'b00, 1'b0, 0);
    endtask

    task automatic test_clean_miss();
        line_valid[0] = 1'b0;
        do_access(20'h01234, 2'b10, 2'b00, 1'b0, 3);
    endtask

    task automatic test_dirty_miss();
        line_valid[2] = 1'b1; line_dirty[2] = 1'b1; line_tag[2] = 20'h0abc6;
        do_access(20'h0fff2, 2'b00, 2'b11, 1'b0, 2);
    endtask

    task automatic test_fault();
        line_valid[3] = 1'b0;
        do_access(20'h00007, 2'b01, 2'b00, 1'b1, 0);
    endtask

    task automatic test_flush();
        int d, n;
        bit seen;
        d = 1;
        for (int i = 0; i < NLINES; i++) begin
            line_valid[i] = 1'b1;
            line_dirty[i] = (i == 1) || (i == 3);
            line_tag[i]   = TW'(20'h05500 + i);
        end
        clear_stats();
        gnt_delay = d;
        bus.flush_req = 1'b1;
        seen = 1'b0;
        n = 0;
        while (n < 300) begin
            step();
            n++;
            if (bus.flush_busy) begin
                seen = 1'b1;
                bus.flush_req = 1'b0;
            end else if (seen) break;
        end
        bus.flush_req = 1'b0;
        $display("flush dirty=1,3 gnt_delay=%0d busy_cycles=%0d writebacks=%0d", d, busy_cycles, wb_idx_q.size());
        vectors++;
        if (wb_idx_q.size() != 2) begin
            miscompares++;
            $display("FAIL flush_wb_count: got %0d writebacks, required 2", wb_idx_q.size());
        end else begin
            vectors++;
            if (wb_idx_q[0] != 1 || wb_idx_q[1] != 3 || wb_tag_q[0] !== 20'h05501 || wb_tag_q[1] !== 20'h05503) begin
                miscompares++;
                $display("FAIL flush_order: got idx %0d,%0d tags %h,%h, required idx 1,3 tags 05501,05503",
                         wb_idx_q[0], wb_idx_q[1], wb_tag_q[0], wb_tag_q[1]);
            end
        end
        vectors++;
        if (busy_cycles != NLINES + 2 + 2 * (d + 1 + NIB) || sig_bad != 0 || bus.flush_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_busy: got %0d busy cycles, %0d sel/flush_write mismatches, busy now %0d; required %0d, 0, 0",
                     busy_cycles, sig_bad, bus.flush_busy, NLINES + 2 + 2 * (d + 1 + NIB));
        end
    endtask

    task automatic test_reset_mid_fill();
        int n;
        line_valid[0] = 1'b0;
        clear_stats();
        gnt_delay     = 2;
        cpu_line      = 20'h02220;
        bus.cpu_read  = 2'b01;
        n = 0;
        while (w_cycles < 4 && n < 100) begin
            step();
            n++;
        end
        vectors++;
        if (bus.c_wstrobe !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_beat4: got c_wstrobe=%0d before reset, required 1", bus.c_wstrobe);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.c_wstrobe !== 1'b0 || bus.mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_fill: got c_wstrobe=%0d mem_req=%0d, required 0 0", bus.c_wstrobe, bus.mem_req);
        end
        bus.cpu_read = 2'b00;
        bus.mem_gnt  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        clear_stats();
        repeat (3) step();
        vectors++;
        if (req_cycles != 0 || w_cycles != 0 || fill_tag_q.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got req=%0d wstrobe=%0d fills=%0d, required 0", req_cycles, w_cycles, fill_tag_q.size());
        end
        $display("reset during fill beat 4 line=%h", cpu_line);
        do_access(20'h02220, 2'b01, 2'b00, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] line;
        logic [1:0] lanes;
        bit wr, flt;
        for (int k = 0; k < 40; k++) begin
            line  = TW'(20'h3a000 + $urandom_range(0, 3) * NLINES + $urandom_range(0, NLINES - 1));
            lanes = 2'($urandom_range(1, 3));
            wr    = $urandom_range(0, 1) == 1;
            flt   = $urandom_range(0, 7) == 0;
            do_access(line, wr ? 2'b00 : lanes, wr ? lanes : 2'b00, flt, int'($urandom_range(0, 4)));
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.cpu_read  = 2'b00;
        bus.cpu_write = 2'b00;
        bus.cpu_fault = 1'b0;
        bus.flush_req = 1'b0;
        bus.mem_gnt   = 1'b0;
        cpu_line      = '0;
        for (int i = 0; i < NLINES; i++) begin
            line_valid[i] = 1'b0;
            line_dirty[i] = 1'b0;
            line_tag[i]   = '0;
        end
        test_reset();
        test_hit();
        test_clean_miss();
        test_dirty_miss();
        test_fault();
        test_flush();
        test_reset_mid_fill();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
